// File: rtl/decomp_line_sched_if.sv
// Line-memory read port between the scanline scheduler and the line memory.
interface decomp_line_sched_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic                  MemRd;
  logic                  MemValid;
  logic [7:0]            MemData;

  modport master (output MemAddr, MemRd, input MemValid, MemData);
  modport slave  (input MemAddr, MemRd, output MemValid, MemData);
endinterface

// File: rtl/decomp_line_sched.sv
// Scanline scheduler for the 3-byte-to-4-pixel decompositor: fetches packed bytes,
// pushes them three per group and pops four pixels per group under consumer backpressure.
module decomp_line_sched #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 11
) (
  input  logic                   Clk,
  input  logic                   ResetN,
  input  logic                   LineStart,
  input  logic [ADDR_WIDTH-1:0]  LineBase,
  input  logic [COUNT_WIDTH-1:0] PixelCount,
  input  logic                   LineAbort,
  decomp_line_sched_if.master    mem,
  output logic                   PushEn,
  output logic [7:0]             PushData,
  output logic                   PopEn,
  input  logic                   PixReady,
  output logic                   PixValid,
  output logic                   DecompFlush,
  output logic                   Busy,
  output logic                   LineDone
);

  // One extra bit so a count rounded up to a multiple of 4 cannot wrap.
  localparam int unsigned CW = COUNT_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [CW-1:0]         r_bytes;
  logic [CW-1:0]         r_pix;
  logic [1:0]            r_group;
  logic [1:0]            r_phase;
  logic                  r_outst;
  logic                  r_mem_rd;
  logic                  r_push_en;
  logic [7:0]            r_push_data;
  logic                  r_pop_en;
  logic                  r_pix_valid;
  logic                  r_flush;
  logic                  r_busy;
  logic                  r_line_done;

  logic [CW-1:0] w_pix_round;
  logic [CW-1:0] w_groups;
  logic [CW-1:0] w_bytes;
  logic [1:0]    w_need;
  logic          w_fetch;
  logic          w_pop;
  logic          w_wrap;

  always_comb begin
    w_pix_round = ({1'b0, PixelCount} + CW'(3)) & ~CW'(3);
    w_groups    = w_pix_round >> 2;
    w_bytes     = (w_groups << 1) + w_groups;
  end

  always_comb begin
    w_need = 2'd3;
    case (r_phase)
      2'd0:    w_need = 2'd1;
      2'd1:    w_need = 2'd2;
      default: w_need = 2'd3;
    endcase
  end

  // GroupBytes counts bytes already strobed into the decompositor; a captured byte
  // waiting in the push register still counts as outstanding, so it blocks the fetch.
  assign w_fetch = (r_state == S_RUN) && (r_bytes != '0) && !r_outst && !r_push_en &&
                   (r_group != 2'd3);
  assign w_pop   = (r_state == S_RUN) && PixReady && (r_group >= w_need);
  assign w_wrap  = w_pop && (r_phase == 2'd3);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_bytes     <= '0;
      r_pix       <= '0;
      r_group     <= '0;
      r_phase     <= '0;
      r_outst     <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_push_en   <= 1'b0;
      r_push_data <= '0;
      r_pop_en    <= 1'b0;
      r_pix_valid <= 1'b0;
      r_flush     <= 1'b0;
      r_busy      <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_mem_rd    <= 1'b0;
      r_push_en   <= 1'b0;
      r_pop_en    <= 1'b0;
      r_flush     <= 1'b0;
      r_line_done <= 1'b0;
      r_pix_valid <= r_pop_en;

      if (LineAbort && (r_state != S_IDLE)) begin
        r_flush <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= S_IDLE;
        r_bytes <= '0;
        r_pix   <= '0;
        r_group <= '0;
        r_phase <= '0;
        r_outst <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (LineStart && !LineAbort) begin
              r_addr  <= LineBase;
              r_pix   <= w_pix_round;
              r_bytes <= w_bytes;
              r_group <= '0;
              r_phase <= '0;
              r_outst <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= (PixelCount == '0) ? S_DONE : S_RUN;
            end
          end

          S_RUN: begin
            if (w_fetch) begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_addr;
              r_addr     <= r_addr + ADDR_WIDTH'(1);
              r_bytes    <= r_bytes - CW'(1);
              r_outst    <= 1'b1;
            end
            if (mem.MemValid && r_outst) begin
              r_push_en   <= 1'b1;
              r_push_data <= mem.MemData;
              r_outst     <= 1'b0;
            end
            // A byte pushed on the phase-3 wrap already belongs to the next group.
            if (w_wrap) r_group <= {1'b0, r_push_en};
            else        r_group <= r_group + {1'b0, r_push_en};
            if (w_pop) begin
              r_pop_en <= 1'b1;
              r_phase  <= r_phase + 2'd1;
              r_pix    <= r_pix - CW'(1);
              if (r_pix == CW'(1)) r_state <= S_DONE;
            end
          end

          S_DONE: begin
            // Hold until the final PopEn has turned into PixValid.
            if (!r_pop_en) begin
              r_line_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem.MemAddr = r_mem_addr;
  assign mem.MemRd   = r_mem_rd;
  assign PushEn      = r_push_en;
  assign PushData    = r_push_data;
  assign PopEn       = r_pop_en;
  assign PixValid    = r_pix_valid;
  assign DecompFlush = r_flush;
  assign Busy        = r_busy;
  assign LineDone    = r_line_done;

endmodule

// File: tb/tb_decomp_line_sched.sv
// Randomized bench for decomp_line_sched: memory responder, event logs and a line-level reference model.
module tb_decomp_line_sched;

  logic        Clk;
  logic        ResetN;
  logic        LineStart;
  logic [15:0] LineBase;
  logic [10:0] PixelCount;
  logic        LineAbort;
  logic        PushEn;
  logic [7:0]  PushData;
  logic        PopEn;
  logic        PixReady;
  logic        PixValid;
  logic        DecompFlush;
  logic        Busy;
  logic        LineDone;

  decomp_line_sched_if #(.ADDR_WIDTH(16)) mem_bus ();

  decomp_line_sched #(.ADDR_WIDTH(16), .COUNT_WIDTH(11)) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .LineStart   (LineStart),
    .LineBase    (LineBase),
    .PixelCount  (PixelCount),
    .LineAbort   (LineAbort),
    .mem         (mem_bus.master),
    .PushEn      (PushEn),
    .PushData    (PushData),
    .PopEn       (PopEn),
    .PixReady    (PixReady),
    .PixValid    (PixValid),
    .DecompFlush (DecompFlush),
    .Busy        (Busy),
    .LineDone    (LineDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          lat_min, lat_max, ready_pct, start_cyc;
  int          rsp_cnt = 0;
  logic [15:0] rsp_addr;
  logic [7:0]  seed_b;
  logic        prev_busy;

  int          rd_cyc[$];
  logic [15:0] rd_addr[$];
  int          push_cyc[$];
  logic [7:0]  push_dat[$];
  int          pop_cyc[$];
  int          pv_cyc[$];
  int          done_cyc[$];
  logic        done_busy[$];
  logic        done_pbusy[$];
  int          fl_cyc[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd29;
    return lo ^ a[15:8] ^ seed_b;
  endfunction

  function automatic int count_lt(input int q[$], input int c);
    int n = 0;
    foreach (q[i]) if (q[i] < c) n++;
    return n;
  endfunction

  function automatic int count_gt(input int q[$], input int c);
    int n = 0;
    foreach (q[i]) if (q[i] > c) n++;
    return n;
  endfunction

  function automatic int need_of(input int p);
    return (p == 0) ? 1 : ((p == 1) ? 2 : 3);
  endfunction

  initial forever begin
    @(posedge Clk);
    cyc = cyc + 1;
  end

  // Event logger: every DUT output strobe, stamped with the cycle it is visible in.
  initial begin
    prev_busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (mem_bus.MemRd) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(mem_bus.MemAddr);
      end
      if (PushEn) begin
        push_cyc.push_back(cyc);
        push_dat.push_back(PushData);
      end
      if (PopEn)       pop_cyc.push_back(cyc);
      if (PixValid)    pv_cyc.push_back(cyc);
      if (DecompFlush) fl_cyc.push_back(cyc);
      if (LineDone) begin
        done_cyc.push_back(cyc);
        done_busy.push_back(Busy);
        done_pbusy.push_back(prev_busy);
      end
      prev_busy = Busy;
    end
  end

  // Line memory: answers each read after a random latency of lat_min..lat_max cycles.
  initial begin
    mem_bus.MemValid = 1'b0;
    mem_bus.MemData  = '0;
    forever begin
      @(negedge Clk);
      mem_bus.MemValid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_bus.MemValid = 1'b1;
          mem_bus.MemData  = mem_byte(rsp_addr);
        end
      end
      if (mem_bus.MemRd) begin
        rsp_addr = mem_bus.MemAddr;
        rsp_cnt  = $urandom_range(lat_max, lat_min);
      end
    end
  end

  initial begin
    PixReady = 1'b0;
    forever begin
      @(negedge Clk);
      PixReady = ($urandom_range(99, 0) < ready_pct);
    end
  end

  task automatic clear_logs();
    rd_cyc.delete();  rd_addr.delete();  push_cyc.delete(); push_dat.delete();
    pop_cyc.delete(); pv_cyc.delete();   done_cyc.delete(); done_busy.delete();
    done_pbusy.delete(); fl_cyc.delete();
  endtask

  task automatic launch(input logic [15:0] base, input int pc);
    @(negedge Clk);
    LineStart  = 1'b1;
    LineBase   = base;
    PixelCount = 11'(pc);
    start_cyc  = cyc;
    @(negedge Clk);
    LineStart  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cyc.size() == 0 && t < 3000) begin
      @(negedge Clk);
      t++;
    end
    if (done_cyc.size() == 0) chk("done_timeout", 0, 1);
  endtask

  // Reference model: a line of pc pixels is ceil(pc/4) groups of 3 bytes read from
  // base upward, with pops gated by bytes pushed and fetches gated by completed groups.
  task automatic verify_line(input logic [15:0] base, input int pc);
    int groups, nb, np, lim;
    groups = (pc + 3) / 4;
    nb = groups * 3;
    np = groups * 4;
    chk("rd_count",   rd_cyc.size(),   nb);
    chk("push_count", push_cyc.size(), nb);
    chk("pop_count",  pop_cyc.size(),  np);
    chk("pv_count",   pv_cyc.size(),   np);
    chk("done_count", done_cyc.size(), 1);
    chk("no_flush",   fl_cyc.size(),   0);
    lim = (rd_cyc.size() < nb) ? rd_cyc.size() : nb;
    for (int i = 0; i < lim; i++) begin
      chk("rd_addr", rd_addr[i], 16'(base + 16'(i)));
      if (i > 0 && i - 1 < push_cyc.size())
        chk("one_outstanding", rd_cyc[i] > push_cyc[i-1], 1);
      if (i >= 3)
        chk("group_gate", count_lt(pop_cyc, rd_cyc[i]) >= 4 * (i / 3), 1);
    end
    lim = (push_cyc.size() < nb) ? push_cyc.size() : nb;
    for (int i = 0; i < lim; i++)
      chk("push_data", push_dat[i], mem_byte(16'(base + 16'(i))));
    for (int j = 0; j < pop_cyc.size(); j++) begin
      chk("pop_needs_bytes",
          count_lt(push_cyc, pop_cyc[j]) >= 3 * (j / 4) + need_of(j % 4), 1);
      if (j < pv_cyc.size()) chk("pv_align", pv_cyc[j], pop_cyc[j] + 1);
    end
    if (done_cyc.size() > 0) begin
      if (np == 0)               chk("done_cycle", done_cyc[0], start_cyc + 2);
      else if (pv_cyc.size() > 0) chk("done_cycle", done_cyc[0], pv_cyc[pv_cyc.size()-1] + 1);
      chk("busy_at_done",     done_busy[0],  0);
      chk("busy_before_done", done_pbusy[0], 1);
    end
  endtask

  task automatic run_line(input logic [15:0] base, input int pc, input bit mid_start,
                          input int hold);
    int saved;
    saved = ready_pct;
    clear_logs();
    if (hold > 0) ready_pct = 0;
    launch(base, pc);
    if (mid_start) begin
      repeat (2) @(negedge Clk);
      chk("busy_mid_line", Busy, 1);
      LineStart  = 1'b1;
      LineBase   = 16'h1234;
      PixelCount = 11'd100;
      @(negedge Clk);
      LineStart  = 1'b0;
    end
    if (hold > 0) begin
      repeat (hold) @(negedge Clk);
      chk("hold_reads",  rd_cyc.size(),   3);
      chk("hold_pushes", push_cyc.size(), 3);
      chk("hold_pops",   pop_cyc.size(),  0);
      ready_pct = saved;
    end
    wait_done();
    repeat (10) @(negedge Clk);
    verify_line(base, pc);
    chk("idle_after_line", Busy, 0);
  endtask

  initial begin
    int t, abort_cyc;
    ResetN = 1'b0; LineStart = 1'b0; LineAbort = 1'b0;
    LineBase = '0; PixelCount = '0;
    lat_min = 2; lat_max = 2; ready_pct = 100;
    seed_b = 8'($urandom);
    repeat (2) @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_addr", mem_bus.MemAddr, 0);
    chk("rst_pushdata", PushData, 0);
    chk("rst_strobes", {mem_bus.MemRd, PushEn, PopEn, PixValid, DecompFlush, LineDone}, 0);
    ResetN = 1'b1;
    repeat (2) @(negedge Clk);

    run_line(16'h0100, 8, 0, 0);
    run_line(16'h0200, 5, 0, 0);
    run_line(16'h0300, 0, 0, 0);

    lat_min = 5; lat_max = 5;
    run_line(16'h0400, 8, 0, 60);
    run_line(16'h0480, 12, 0, 0);

    // Abort with a read in flight; the late MemValid must be dropped.
    clear_logs();
    launch(16'h0500, 16);
    t = 0;
    while (rd_cyc.size() < 3 && t < 200) begin
      @(negedge Clk);
      t++;
    end
    chk("abort_setup_reads", rd_cyc.size() >= 3, 1);
    LineAbort = 1'b1;
    abort_cyc = cyc;
    @(negedge Clk);
    LineAbort = 1'b0;
    chk("abort_flush_now", DecompFlush, 1);
    chk("abort_busy_now", Busy, 0);
    repeat (20) @(negedge Clk);
    chk("abort_flush_count", fl_cyc.size(), 1);
    if (fl_cyc.size() > 0) chk("abort_flush_cycle", fl_cyc[0], abort_cyc + 1);
    chk("abort_late_push", count_gt(push_cyc, abort_cyc), 0);
    chk("abort_late_read", count_gt(rd_cyc, abort_cyc), 0);
    chk("abort_no_done", done_cyc.size(), 0);
    chk("abort_busy", Busy, 0);
    run_line(16'h0600, 8, 0, 0);

    lat_min = 1; lat_max = 3;
    run_line(16'hFFFE, 4, 1, 0);

    // Start and abort together while idle: the abort wins and nothing starts.
    clear_logs();
    @(negedge Clk);
    LineStart = 1'b1; LineAbort = 1'b1; LineBase = 16'h0700; PixelCount = 11'd8;
    @(negedge Clk);
    LineStart = 1'b0; LineAbort = 1'b0;
    repeat (10) @(negedge Clk);
    chk("start_abort_busy", Busy, 0);
    chk("start_abort_reads", rd_cyc.size(), 0);
    chk("start_abort_flush", fl_cyc.size(), 0);

    // Asynchronous reset in the middle of a line.
    ready_pct = 50;
    clear_logs();
    launch(16'h0800, 40);
    repeat (15) @(negedge Clk);
    chk("busy_pre_reset", Busy, 1);
    #2 ResetN = 1'b0;
    #1;
    chk("reset_busy", Busy, 0);
    chk("reset_addr", mem_bus.MemAddr, 0);
    chk("reset_pushdata", PushData, 0);
    chk("reset_strobes", {mem_bus.MemRd, PushEn, PopEn, PixValid, DecompFlush, LineDone}, 0);
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    rsp_cnt = 0;
    repeat (2) @(negedge Clk);
    run_line(16'h0900, 8, 0, 0);

    lat_min = 1; lat_max = 6;
    for (int n = 0; n < 15; n++) begin
      ready_pct = $urandom_range(100, 30);
      run_line(16'($urandom), $urandom_range(40, 0), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decomp_line_sched.md
Name: decomp_line_sched

Overview:
- Single-clock scheduler that feeds one scanline through the 3-byte-to-4-pixel decompositor (8-bit words in, 6-bit pixels out).
- Fetches packed bytes from line memory, pushes them into the decompositor in groups of 3, and pops 4 pixels per group under consumer backpressure.
- Signals line completion.
- Sits between the line-memory read port and the VGA pixel pipeline.

Parameters:
ADDR_WIDTH, 16, line-memory byte address width
COUNT_WIDTH, 11, width of pixel count and internal pixel/byte counters

Ports:
Clk  input  1  system clock, all logic on rising edge
ResetN  input  1  asynchronous active-low reset
LineStart  input  1  one-cycle pulse: begin a line
LineBase  input  ADDR_WIDTH  byte address of first packed byte, sampled on LineStart
PixelCount  input  COUNT_WIDTH  pixels in line, sampled on LineStart
LineAbort  input  1  one-cycle pulse: abandon current line
MemAddr  output  ADDR_WIDTH  read address
MemRd  output  1  one-cycle read request
MemValid  input  1  read data valid, arbitrary latency >=1 cycle
MemData  input  8  read data
PushEn  output  1  write strobe to decompositor input
PushData  output  8  byte to decompositor
PopEn  output  1  read strobe to decompositor output
PixReady  input  1  consumer can accept a pixel this cycle
PixValid  output  1  decompositor DataOut holds a new pixel this cycle
DecompFlush  output  1  one-cycle pulse: clear decompositor indices
Busy  output  1  line in progress
LineDone  output  1  one-cycle pulse after last pixel popped

Behaviour:
- Reset: all outputs 0 (MemAddr = 0, PushData = 0), state IDLE, all counters 0.
- States: IDLE, RUN, DONE.
- IDLE + LineStart:
  - latch address = LineBase; pixels = PixelCount rounded up to a multiple of 4.
  - bytes = pixels/4*3.
  - GroupBytes = 0, PixPhase = 0, Busy = 1, go to RUN.
  - PixelCount = 0: go directly to DONE.
- LineStart while not IDLE is ignored.
- Fetch, RUN only:
  - issue MemRd with MemAddr = address when bytes remaining > 0, no read outstanding, and GroupBytes + outstanding < 3.
  - At most one read outstanding.
  - address increments by 1 per issued read; wraps modulo 2^ADDR_WIDTH.
- Push:
  - on MemValid with a read outstanding, the next cycle PushEn = 1, PushData = MemData, GroupBytes + 1.
  - MemValid with nothing outstanding is ignored.
- Pop:
  - PopEn = 1 when in RUN, PixReady = 1, and GroupBytes >= need[PixPhase].
  - need = {1, 2, 3, 3} for phase 0..3.
  - PixPhase increments; wraps 3 -> 0.
  - On wrap, GroupBytes resets to 0, which reopens fetch for the next group.
  - Push and pop in the same cycle are both legal.
  - If they coincide with the phase-3 wrap, GroupBytes = 1 (the pushed byte belongs to the next group), and the following fetch is still gated.
- PixValid = PopEn delayed one cycle, aligned with the decompositor's registered DataOut.
- Pixel counter decrements per pop. The pop that takes it to 0 moves state to DONE.
- DONE: LineDone = 1 for one cycle, cycle after last PixValid; then IDLE, Busy = 0.
- LineAbort, any non-IDLE state:
  - next cycle DecompFlush = 1; go to IDLE, Busy = 0.
  - Counters cleared, LineDone not asserted.
  - A MemValid arriving later is dropped.
  - LineAbort in IDLE: no effect.
- LineStart and LineAbort in the same cycle: abort wins.
- Reset mid-line: immediate return to reset values. The decompositor must be reset or flushed by the top level.

Test Plan:
- LineStart, LineBase = 0x0100, PixelCount = 8, MemValid 2 cycles after each MemRd, PixReady = 1 -> reads at 0x0100..0x0105, six PushEn, eight PopEn, PixValid 1 cycle after each PopEn, LineDone once, Busy falls with it.
- PixelCount = 5 -> rounded to 8 pixels, 6 reads, 8 pops.
- PixelCount = 0 -> no MemRd, LineDone 2 cycles after LineStart.
- PixReady held 0 after first group fills -> exactly 3 pushes, no further MemRd until 4 pops complete; pop for phase 1 waits for second byte when memory is slow (latency 5).
- LineAbort after 2 pushes, then MemValid arrives -> DecompFlush pulse, no PushEn, no LineDone, Busy = 0; a new LineStart restarts cleanly from its LineBase.
- LineBase = 0xFFFE (ADDR_WIDTH = 16), PixelCount = 4 -> reads at 0xFFFE, 0xFFFF, 0x0000; LineStart during Busy ignored; ResetN low mid-line clears all outputs asynchronously.
